// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // All segments off (active-low)
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} pattern per hex digit, entry 15 first
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern
    always_comb begin
        seg = HEX_SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller with blanking gap between digits.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_blank,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             capture;

    logic [4*NUM_DIGITS-1:0] sh_value;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic                    sh_lz;

    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic                  frame_done_nxt;

    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  upper_zero;
    logic [3:0]            cur_nib;
    logic                  cur_en;
    logic                  cur_dp;
    logic                  cur_lzb;
    logic [6:0]            dec_seg;

    // Leading-zero mask from the shadow copy and selection of the current digit's fields
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        cur_nib    = '0;
        cur_en     = 1'b0;
        cur_dp     = 1'b0;
        cur_lzb    = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            upper_zero = upper_zero && (sh_value[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            lz_mask[NUM_DIGITS-1-k] = sh_lz && upper_zero && (k != NUM_DIGITS - 1);
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = sh_value[4*i +: 4];
                cur_en  = sh_en[i];
                cur_dp  = sh_dp[i];
                cur_lzb = lz_mask[i];
            end
        end
    end

    hex_to_seg7 u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Next-state and next-output logic; outputs are registered from the current
    // state, so the first SHOW cycle lights the digit one edge after the
    // counter reaches zero and a tick blanks the outputs on the same edge.
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        cnt_nxt        = cnt;
        capture        = 1'b0;
        an_nxt         = '1;
        seg_nxt        = SEG_OFF;
        dp_nxt         = 1'b1;
        frame_done_nxt = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == '0) begin
                    state_nxt = SHOW;
                    capture   = (idx == '0);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            SHOW: begin
                if (tick) begin
                    state_nxt      = BLANK;
                    cnt_nxt        = CNT_RELOAD;
                    idx_nxt        = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    frame_done_nxt = (idx == IDX_LAST);
                end else if (cur_en && !cur_lzb) begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        an_nxt[i] = (idx != IDX_W'(i));
                    end
                    seg_nxt = dec_seg;
                    dp_nxt  = ~cur_dp;
                end
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase
    end

    // State, counters, shadow capture and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            idx        <= '0;
            cnt        <= CNT_RELOAD;
            sh_value   <= '0;
            sh_dp      <= '0;
            sh_en      <= '0;
            sh_lz      <= 1'b0;
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_done_nxt;
            if (capture) begin
                sh_value <= value;
                sh_dp    <= dp_mask;
                sh_en    <= digit_en;
                sh_lz    <= lz_blank;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a scoreboard of expected digit slots.
module tb_seg7_scan_ctrl;

    localparam int ND   = 4;
    localparam int BC   = 4;
    localparam int HOLD = 100 - BC - 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [3:0]  digit_en = 4'hF;
    logic        lz_blank = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;

    localparam disp_t ALL_OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

    disp_t       exp_q[$];
    disp_t       last_exp;
    int unsigned checks = 0;
    int unsigned passed = 0;

    int          m_idx = 0;
    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_en;
    logic        m_lz;

    seg7_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .value      (value),
        .dp_mask    (dp_mask),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Active-high {g..a} patterns, inverted for the active-low display
    function automatic logic [6:0] seg_high(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic disp_t model_disp(input int i);
        disp_t d;
        logic [15:0] upper;
        logic blanked;
        logic [3:0] nib;
        upper   = m_value >> (4 * i);
        nib     = upper[3:0];
        blanked = m_lz && (i > 0) && (upper == 16'h0);
        if (m_en[i] && !blanked) begin
            d.an  = ~(4'b0001 << i);
            d.seg = ~seg_high(nib);
            d.dp  = ~m_dp[i];
        end else begin
            d = ALL_OFF;
        end
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that blanked the display; checks the gap and the lit digit.
    task automatic wait_lit(input string name, input bit tick_in_gap);
        disp_t got;
        disp_t exp;
        bit    gap_ok = 1'b1;
        if (m_idx == 0) begin
            m_value = value;
            m_dp    = dp_mask;
            m_en    = digit_en;
            m_lz    = lz_blank;
        end
        exp_q.push_back(model_disp(m_idx));
        for (int k = 0; k <= BC; k++) begin
            if (k > 0) step();
            tick = (tick_in_gap && k == 1);
            if ({an, seg, dp} !== ALL_OFF) gap_ok = 1'b0;
            if (k > 0 && frame_done !== 1'b0) gap_ok = 1'b0;
        end
        step();
        tick = 1'b0;
        checks++;
        if (!gap_ok) $display("FAIL %s_gap slot %0d: display not dark for %0d cycles", name, m_idx, BC + 1);
        else passed++;
        got = {an, seg, dp};
        exp = exp_q.pop_front();
        last_exp = exp;
        checks++;
        if (got !== exp)
            $display("FAIL %s_lit slot %0d: an/seg/dp got %b/%b/%b want %b/%b/%b",
                     name, m_idx, got.an, got.seg, got.dp, exp.an, exp.seg, exp.dp);
        else passed++;
    endtask

    task automatic end_slot(input string name);
        logic want_fd;
        repeat (HOLD) step();
        checks++;
        if ({an, seg, dp} !== last_exp)
            $display("FAIL %s_hold slot %0d: got %b/%b/%b want %b/%b/%b",
                     name, m_idx, an, seg, dp, last_exp.an, last_exp.seg, last_exp.dp);
        else passed++;
        tick = 1'b1;
        step();
        tick = 1'b0;
        want_fd = (m_idx == ND - 1);
        checks++;
        if (frame_done !== want_fd)
            $display("FAIL %s_frame_done slot %0d: got %b want %b", name, m_idx, frame_done, want_fd);
        else passed++;
        m_idx = (m_idx + 1) % ND;
    endtask

    task automatic test_reset();
        value    = 16'h1234;
        dp_mask  = 4'h0;
        digit_en = 4'hF;
        lz_blank = 1'b0;
        reset    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({an, seg, dp, frame_done} !== {ALL_OFF, 1'b0})
                $display("FAIL reset_state cycle %0d: got %b/%b/%b/%b want 1111/1111111/1/0",
                         c, an, seg, dp, frame_done);
            else passed++;
        end
        reset = 1'b0;
        m_idx = 0;
        wait_lit("reset_tick_ignored", 1'b1);
        end_slot("reset_tick_ignored");
    endtask

    task automatic test_scan();
        while (m_idx != 0) begin
            wait_lit("scan", 1'b0);
            end_slot("scan");
        end
        for (int s = 0; s < ND; s++) begin
            wait_lit("scan", 1'b0);
            end_slot("scan");
        end
    endtask

    task automatic test_lz();
        value    = 16'h0040;
        lz_blank = 1'b1;
        for (int s = 0; s < ND; s++) begin
            wait_lit("lz", 1'b0);
            end_slot("lz");
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_shadow();
        value = 16'h1111;
        for (int s = 0; s < ND; s++) begin
            wait_lit("shadow", 1'b0);
            if (s == 1) value = 16'h2222;
            end_slot("shadow");
        end
        for (int s = 0; s < ND; s++) begin
            wait_lit("shadow_next", 1'b0);
            end_slot("shadow_next");
        end
    endtask

    task automatic test_dp_en();
        value    = 16'h1234;
        dp_mask  = 4'b0100;
        digit_en = 4'b1101;
        for (int s = 0; s < ND; s++) begin
            wait_lit("dp_en", 1'b0);
            end_slot("dp_en");
        end
        dp_mask  = 4'h0;
        digit_en = 4'hF;
    endtask

    task automatic test_reset_mid();
        value = 16'hABCD;
        for (int s = 0; s < 2; s++) begin
            wait_lit("pre_reset", 1'b0);
            end_slot("pre_reset");
        end
        wait_lit("pre_reset", 1'b0);
        value = 16'h5678;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({an, seg, dp, frame_done} !== {ALL_OFF, 1'b0})
            $display("FAIL reset_mid: got %b/%b/%b/%b want 1111/1111111/1/0", an, seg, dp, frame_done);
        else passed++;
        m_idx = 0;
        for (int s = 0; s < ND; s++) begin
            wait_lit("post_reset", 1'b0);
            end_slot("post_reset");
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_shadow();
        test_dp_en();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Display scan controller for the four-digit seven-segment display. It consumes the one-cycle refresh tick from the display clock divider and time-multiplexes a hex value across the digit anodes. It inserts an all-off blanking gap at every digit switch to prevent ghosting. Sits between the display divider and the board's anode/segment pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits; index 0 is the rightmost (least significant) digit.
BLANK_CYCLES, 16, clk cycles with all anodes off between digits; must be >=1 and less than the tick period.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-clk pulse from the display divider; one digit slot per tick
value  in  4*NUM_DIGITS  hex value; nibble i drives digit i
dp_mask  in  NUM_DIGITS  bit i=1 lights the decimal point on digit i
digit_en  in  NUM_DIGITS  bit i=0 forces digit i dark
lz_blank  in  1  1 = suppress leading zeros
an  out  NUM_DIGITS  anodes, active-low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Clocking and reset: single clock domain on clk; reset is synchronous and active-high.
- Reset values: an = all 1, seg = 7'b1111111, dp = 1, frame_done = 0.
- Reset internal state: state = BLANK, idx = 0, blank counter = BLANK_CYCLES-1, shadow registers = 0.
- States: BLANK and SHOW.
- BLANK:
  - an, seg and dp are all held off.
  - The counter decrements each clk.
  - When the counter is 0, the next state is SHOW.
  - Ticks arriving in BLANK are ignored (dropped, not queued).
- Shadow capture: on the BLANK->SHOW transition into idx 0, value, dp_mask, digit_en and lz_blank are captured into shadow registers. The whole frame displays the shadow copy, so input changes mid-frame appear in the next frame only.
- SHOW:
  - Outputs are registered. an, seg and dp take the digit-idx values in the first SHOW cycle, which is the cycle after the counter reached 0.
  - The outputs hold until a tick.
  - On tick: next state is BLANK, all outputs go off, and the counter reloads to BLANK_CYCLES-1.
  - On tick, idx advances; it wraps from NUM_DIGITS-1 to 0.
  - If idx was NUM_DIGITS-1 when the tick arrived, frame_done=1 for exactly that one cycle.
- Digit lit rule: an[idx]=0 only when all of the following hold:
  - state is SHOW;
  - shadow digit_en[idx]=1;
  - the digit is not leading-zero blanked.
- Leading-zero blanking: digit i with i>0 is blanked when shadow lz_blank=1 and every nibble at positions >= i is zero. Digit 0 is never leading-zero blanked, so value 0 shows a single "0".
- Dark digit: when a digit is dark in SHOW, an stays all 1. seg and dp are also driven off.
- Segment decode: hex 0-F, active-low. Examples:
  - 0 = 1000000
  - 4 = 0011001
  - 8 = 0000000
  - F = 0001110
- Decimal point: dp = ~shadow dp_mask[idx] in SHOW; dp = 1 otherwise.
- Reset mid-operation: outputs go to their reset values on the next edge. The scan restarts at BLANK with idx 0, and shadows are recaptured at the first SHOW.
- Timing: from tick to the next digit lit is exactly BLANK_CYCLES+1 clk cycles.
- Widths: idx is $clog2(NUM_DIGITS) bits, with minimum 1. The counter is $clog2(BLANK_CYCLES+1) bits.

Decomposition:
- Shared package seg7_pkg:
  - state enum {BLANK, SHOW};
  - constant SEG_OFF = 7'b1111111;
  - the 16-entry active-low hex segment table.
- One sub-module, hex_to_seg7: combinational nibble -> active-low seg[6:0] using the package table. Instantiated once on the idx-selected nibble.

Test Plan:
1. Reset held 3 cycles -> an=1111, seg=1111111, dp=1, frame_done=0 throughout; first tick after release ignored while in BLANK.
2. BLANK_CYCLES=4, tick every 100 clk, value=16'h1234, digit_en=1111, lz_blank=0 -> sequence:
   - an=1110 with seg=0011001 ("4");
   - then 3, 2, 1 on an=1101/1011/0111;
   - each tick followed by 5 cycles of an=1111;
   - frame_done pulses once per 4 ticks.
3. value=16'h0040, lz_blank=1 -> digits 3 and 2 dark (an stays 1111 in their slots); digit 1 shows 0011001; digit 0 shows 1000000.
4. value=16'h1111, switched to 16'h2222 while digit 1 is shown -> digits 2 and 3 still show "1"; the next frame shows "2" on all digits.
5. dp_mask=0100, digit_en=1101 -> dp=0 only in the digit 2 slot; digit 1 slot has an=1111, seg=1111111, dp=1.
6. reset pulsed during SHOW of digit 2 -> next cycle all outputs off; after BLANK_CYCLES+1 cycles digit 0 is lit with a freshly captured value; no frame_done is emitted for the aborted frame.
